// File: rtl/db_req_arbiter_if.sv
// db_req_arbiter_if: bundles the two parser request ports, their response pulses,
// the key-value DB request/response port, and the drain/status/statistics signals.
// master: the environment side (parsers, DB, control). slave: the arbiter side.
interface db_req_arbiter_if #(
  parameter int KEY_SIZE = 96,
  parameter int FIFO_AW  = 4
);
  logic                req0_valid, req1_valid;
  logic [KEY_SIZE-1:0] req0_key, req1_key;
  logic [3:0]          req0_flag, req1_flag;
  logic                req0_ready, req1_ready;
  logic                resp0_valid, resp1_valid;
  logic [3:0]          resp_flag;
  logic [KEY_SIZE-1:0] in_key;
  logic [3:0]          in_flag;
  logic                in_valid;
  logic                out_valid;
  logic [3:0]          out_flag;
  logic                drain, drained;
  logic [FIFO_AW:0]    outstanding;
  logic                err_orphan;
  logic [15:0]         grant_cnt0, grant_cnt1;
  modport master (
    output req0_valid, req1_valid, req0_key, req1_key, req0_flag, req1_flag,
           out_valid, out_flag, drain,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_flag,
           in_key, in_flag, in_valid, drained, outstanding, err_orphan,
           grant_cnt0, grant_cnt1
  );
  modport slave (
    input  req0_valid, req1_valid, req0_key, req1_key, req0_flag, req1_flag,
           out_valid, out_flag, drain,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_flag,
           in_key, in_flag, in_valid, drained, outstanding, err_orphan,
           grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/db_req_arbiter.sv
// db_req_arbiter: round-robin sharing of one in-order key-value DB port between two parsers.
// Ports: clk156 (clock), eth_rst (sync active-high reset), bus (db_req_arbiter_if.slave:
// req0/req1 valid/key/flag/ready, resp0/resp1 valid + shared resp_flag, DB in_key/in_flag/
// in_valid and out_valid/out_flag, drain/drained, outstanding, err_orphan, grant_cnt0/1).
// Optional macro ARB_STATS_EN builds saturating per-port grant counters; otherwise they read 0.
module db_req_arbiter #(
  parameter int KEY_SIZE = 96,
  parameter int FIFO_AW  = 4
) (
  input logic            clk156,
  input logic            eth_rst,
  db_req_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
  state_t              state, state_nx;
  logic                rr, can_grant, gnt0, gnt1, grant, pop;
  logic [KEY_SIZE-1:0] key_sel;
  logic [3:0]          flag_sel;
  logic [FIFO_AW-1:0]  wp, rp;
  logic                tags [DEPTH];
  // outstanding never exceeds DEPTH, so its MSB alone means full
  always_comb begin
    can_grant = state == RUN && !bus.drain && !bus.outstanding[FIFO_AW] && !eth_rst;
    gnt0      = can_grant && bus.req0_valid && (!bus.req1_valid || !rr);
    gnt1      = can_grant && bus.req1_valid && (!bus.req0_valid || rr);
    grant     = gnt0 || gnt1;
    key_sel   = gnt1 ? bus.req1_key : bus.req0_key;
    flag_sel  = gnt1 ? bus.req1_flag : bus.req0_flag;
    pop       = bus.out_valid && bus.outstanding != '0;
    state_nx  = state == RUN   ? (bus.drain ? DRAIN : RUN) :
                state == DRAIN ? (bus.outstanding == '0 ? DRAINED : DRAIN) :
                                 (bus.drain ? DRAINED : RUN);
  end
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.drained    = state == DRAINED;
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state           <= RUN;
      rr              <= 1'b0;
      wp              <= '0;
      rp              <= '0;
      bus.outstanding <= '0;
      bus.in_valid    <= 1'b0;
      bus.in_key      <= '0;
      bus.in_flag     <= '0;
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
      bus.resp_flag   <= '0;
      bus.err_orphan  <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.in_valid    <= grant;
      // the granted port becomes the non-preferred one, covering both rr rules
      if (grant) begin
        bus.in_key  <= key_sel;
        bus.in_flag <= flag_sel;
        wp          <= wp + 1'b1;
        rr          <= !gnt1;
      end
      if (pop) begin
        rp            <= rp + 1'b1;
        bus.resp_flag <= bus.out_flag;
      end
      bus.resp0_valid <= pop && !tags[rp];
      bus.resp1_valid <= pop && tags[rp];
      if (bus.out_valid && !pop) bus.err_orphan <= 1'b1;
      bus.outstanding <= bus.outstanding + (FIFO_AW+1)'(grant) - (FIFO_AW+1)'(pop);
    end
  end
  always_ff @(posedge clk156)
    if (grant) tags[wp] <= gnt1;
`ifdef ARB_STATS_EN
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      bus.grant_cnt0 <= '0;
      bus.grant_cnt1 <= '0;
    end else begin
      if (gnt0 && bus.grant_cnt0 != 16'hffff) bus.grant_cnt0 <= bus.grant_cnt0 + 16'd1;
      if (gnt1 && bus.grant_cnt1 != 16'hffff) bus.grant_cnt1 <= bus.grant_cnt1 + 16'd1;
    end
  end
`else
  assign bus.grant_cnt0 = 16'h0000;
  assign bus.grant_cnt1 = 16'h0000;
`endif
endmodule

// File: tb/tb_db_req_arbiter.sv
// tb_db_req_arbiter: randomized scoreboard bench for db_req_arbiter against a queue-based model.
module tb_db_req_arbiter;
  localparam int KS = 96;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  db_req_arbiter_if #(.KEY_SIZE(KS), .FIFO_AW(AW)) b ();
  db_req_arbiter #(.KEY_SIZE(KS), .FIFO_AW(AW)) dut (.clk156(clk), .eth_rst(rst), .bus(b));
  int checks = 0;
  int fails = 0;
  bit pv [2];
  bit auto_req [2];
  logic [KS-1:0] pk [2];
  logic [3:0] pf [2];
  int mq [$];
  bit rr_m;
  int mode;
  bit err_m;
  int cnt_m [2];
  logic [KS+3:0] exp_req [$];
  logic [4:0] exp_resp [$];
  bit exp_iv, exp_r0, exp_r1;
  int hist [$];
  logic [4:0] rhist [$];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic new_req(input int p);
    pv[p] = 1'b1;
    pk[p] = {$urandom, $urandom, $urandom};
    pf[p] = 4'($urandom);
  endtask
  task automatic drive(input bit ov, input logic [3:0] fl, input bit dr);
    b.req0_valid = pv[0];
    b.req0_key   = pk[0];
    b.req0_flag  = pf[0];
    b.req1_valid = pv[1];
    b.req1_key   = pk[1];
    b.req1_flag  = pf[1];
    b.out_valid  = ov;
    b.out_flag   = fl;
    b.drain      = dr;
  endtask
  task automatic model_reset();
    mq.delete();
    rr_m = 1'b0;
    mode = M_RUN;
    err_m = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
  endtask
  // one clock cycle: drive inputs, check the model's view of this cycle, advance the model
  task automatic step(input bit ov, input logic [3:0] fl, input bit dr);
    int n, id;
    bit can, g0, g1;
    @(negedge clk);
    drive(ov, fl, dr);
    #1;
    n   = mq.size();
    can = mode == M_RUN && !dr && n < DEPTH;
    g0  = can && pv[0] && (!pv[1] || !rr_m);
    g1  = can && pv[1] && (!pv[0] || rr_m);
    if (b.req1_ready) hist.push_back(1);
    else if (b.req0_ready) hist.push_back(0);
    chk("req0_ready", b.req0_ready, g0);
    chk("req1_ready", b.req1_ready, g1);
    chk("outstanding", b.outstanding, n);
    chk("drained", b.drained, mode == M_DRAINED);
    chk("err_orphan", b.err_orphan, err_m);
    chk("grant_cnt0", b.grant_cnt0, STATS ? cnt_m[0] : 0);
    chk("grant_cnt1", b.grant_cnt1, STATS ? cnt_m[1] : 0);
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (ov && n > 0) begin
      id = mq.pop_front();
      exp_resp.push_back({1'(id), fl});
      exp_r0 = id == 0;
      exp_r1 = id == 1;
    end else if (ov) err_m = 1'b1;
    exp_iv = g0 || g1;
    if (g0 || g1) begin
      id = g1 ? 1 : 0;
      mq.push_back(id);
      exp_req.push_back({pk[id], pf[id]});
      rr_m = !g1;
      if (cnt_m[id] < 65535) cnt_m[id]++;
      if (auto_req[id]) new_req(id);
      else pv[id] = 1'b0;
    end
    if (mode == M_RUN && dr) mode = M_DRAIN;
    else if (mode == M_DRAIN && n == 0) mode = M_DRAINED;
    else if (mode == M_DRAINED && !dr) mode = M_RUN;
  endtask
  task automatic flush();
    bit done;
    done = 1'b0;
    auto_req[0] = 1'b0;
    auto_req[1] = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      done = mq.size() == 0 && !pv[0] && !pv[1] && exp_req.size() == 0 &&
             exp_resp.size() == 0 && mode == M_RUN;
      if (!done) step(mq.size() > 0 && $urandom_range(1) == 1, 4'($urandom), 1'b0);
    end
    if (!done) begin
      fails++;
      checks++;
      $display("FAIL flush_timeout: outstanding model %0d still pending", mq.size());
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    new_req(0);
    new_req(1);
    drive(1'b0, 4'h0, 1'b0);
    exp_iv = 1'b0;
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    #1;
    chk("rst_req0_ready", b.req0_ready, 0);
    chk("rst_req1_ready", b.req1_ready, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_valid", b.in_valid, 0);
    chk("rst_in_key", b.in_key, 0);
    chk("rst_in_flag", b.in_flag, 0);
    chk("rst_resp0", b.resp0_valid, 0);
    chk("rst_resp1", b.resp1_valid, 0);
    chk("rst_resp_flag", b.resp_flag, 0);
    chk("rst_drained", b.drained, 0);
    chk("rst_outstanding", b.outstanding, 0);
    chk("rst_err_orphan", b.err_orphan, 0);
    chk("rst_cnt0", b.grant_cnt0, 0);
    chk("rst_cnt1", b.grant_cnt1, 0);
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask
  // monitor: compares DUT outputs against the scoreboard queues one cycle after each edge
  initial forever begin
    logic [KS+3:0] er;
    logic [4:0] rs;
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("in_valid", b.in_valid, exp_iv);
      chk("resp0_valid", b.resp0_valid, exp_r0);
      chk("resp1_valid", b.resp1_valid, exp_r1);
      if (b.in_valid && exp_req.size() > 0) begin
        er = exp_req.pop_front();
        chk("in_key", b.in_key, er[KS+3:4]);
        chk("in_flag", b.in_flag, er[3:0]);
      end
      if ((b.resp0_valid || b.resp1_valid) && exp_resp.size() > 0) begin
        rs = exp_resp.pop_front();
        rhist.push_back({b.resp1_valid, b.resp_flag});
        chk("resp_port_flag", {b.resp1_valid, b.resp_flag}, rs);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] want_r [3];
    bit dr;
    want_r = '{5'h03, 5'h15, 5'h17};
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    auto_req[0] = 1'b0;
    auto_req[1] = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    model_reset();
    do_reset();
    // both ports streaming from reset: grants alternate starting with port 0
    hist.delete();
    auto_req[0] = 1'b1;
    auto_req[1] = 1'b1;
    new_req(0);
    new_req(1);
    repeat (6) step(1'b0, 4'h0, 1'b0);
    chk("alt_count", hist.size(), 6);
    for (int i = 0; i < hist.size() && i < 6; i++) chk("alt_grant", hist[i], i % 2);
    flush();
    // responses routed in issue order
    do_reset();
    rhist.delete();
    new_req(0);
    step(1'b0, 4'h0, 1'b0);
    new_req(1);
    step(1'b0, 4'h0, 1'b0);
    new_req(1);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    repeat (2) step(1'b0, 4'h0, 1'b0);
    chk("resp_count", rhist.size(), 3);
    for (int i = 0; i < rhist.size() && i < 3; i++) chk("resp_order", rhist[i], want_r[i]);
    chk("outst_zero", b.outstanding, 0);
    // full FIFO blocks grants; one pop admits exactly one more
    flush();
    hist.delete();
    auto_req[0] = 1'b1;
    new_req(0);
    repeat (12) step(1'b0, 4'h0, 1'b0);
    chk("full_grants", hist.size(), DEPTH);
    chk("full_outst", b.outstanding, DEPTH);
    hist.delete();
    step(1'b1, 4'h9, 1'b0);
    repeat (3) step(1'b0, 4'h0, 1'b0);
    chk("refill_grants", hist.size(), 1);
    chk("refill_outst", b.outstanding, DEPTH);
    flush();
    // drain with three outstanding
    new_req(0);
    step(1'b0, 4'h0, 1'b0);
    new_req(1);
    step(1'b0, 4'h0, 1'b0);
    new_req(0);
    step(1'b0, 4'h0, 1'b0);
    hist.delete();
    auto_req[0] = 1'b1;
    auto_req[1] = 1'b1;
    new_req(0);
    new_req(1);
    repeat (4) step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b1);
    step(1'b1, 4'h3, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    chk("drained_lo", b.drained, 0);
    step(1'b0, 4'h0, 1'b1);
    chk("drained_hi", b.drained, 1);
    chk("drain_no_grant", hist.size(), 0);
    repeat (3) step(1'b0, 4'h0, 1'b0);
    chk("drain_resume", hist.size() > 0, 1);
    flush();
    // orphan response
    rhist.delete();
    step(1'b1, 4'hf, 1'b0);
    repeat (3) step(1'b0, 4'h0, 1'b0);
    chk("orphan_no_resp", rhist.size(), 0);
    chk("orphan_err", b.err_orphan, 1);
    new_req(1);
    step(1'b0, 4'h0, 1'b0);
    flush();
    chk("orphan_sticky", b.err_orphan, 1);
    do_reset();
    // randomized traffic with occasional drain
    dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv[0] && $urandom_range(2) == 0) new_req(0);
      if (!pv[1] && $urandom_range(2) == 0) new_req(1);
      if ($urandom_range(63) == 0) dr = !dr;
      step(mq.size() > 0 && $urandom_range(1) == 1, 4'($urandom), dr);
    end
    flush();
`ifdef ARB_STATS_EN
    auto_req[1] = 1'b1;
    new_req(1);
    for (int i = 0; i < 70100; i++) step(mq.size() > 0, 4'($urandom), 1'b0);
    flush();
    chk("cnt1_saturated", b.grant_cnt1, 16'hffff);
`else
    chk("cnt0_tied", b.grant_cnt0, 0);
    chk("cnt1_tied", b.grant_cnt1, 0);
`endif
    repeat (2) step(1'b0, 4'h0, 1'b0);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
